// File: rtl/hazard_pkg.sv
// Shared types and decode helpers for the ID-stage hazard scoreboard.
// Contents:
//   - opcode encodings (RV32 major opcodes plus the custom-0 PIM opcode)
//   - hz_state_e : scoreboard FSM states
//   - uses_rs1 / uses_rs2 / writes_rd / is_ll : register-usage decode,
//     identical to the rules the forwarding unit applies
package hazard_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_PIM    = 7'b0001011;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } hz_state_e;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == OP_JAL || opcode == OP_LUI || opcode == OP_AUIPC);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_R || opcode == OP_STORE ||
            opcode == OP_BRANCH || opcode == OP_PIM);
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode, input logic [4:0] rd);
    return !(opcode == OP_STORE || opcode == OP_BRANCH) && (rd != REG_X0);
  endfunction

  function automatic logic is_ll(input logic [6:0] opcode);
    return (opcode == OP_LOAD || opcode == OP_PIM);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for the scoreboard performance statistics.
// Ports:
//   clk_i  in  clock
//   rst_i  in  async reset, active-high (clears the count)
//   inc_i  in  count one event this cycle
//   cnt_o  out current count, sticks at all-ones
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage issue controller. Tracks destination registers of in-flight
// long-latency ops (LOAD, PIM) and stalls ID on RAW/WAW hazards that the
// WB-only forwarding path cannot cover, on a full long-latency queue, and
// while a drain (fence/ecall) request is open.
// Optional feature: define HAZARD_PERF_EN to build the stall counters;
// otherwise stall_cycles_o / raw_stalls_o are tied to zero.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   id_valid_i/opcode/rs1/rs2/rd   instruction in ID
//   flush_i                 squash the ID instruction (never stalls)
//   ll_wb_valid_i/ll_wb_rd_i      long-latency completion in WB
//   drain_req_i             level request: block issue until empty
//   id_stall_o              hold IF/ID (combinational)
//   drain_done_o            in DRAIN with nothing outstanding
//   pending_o               registered pending-register bitmap
//   outstanding_o           long-latency ops in flight
//   ll_err_o                sticky: completion with nothing outstanding
//   stall_cycles_o          valid & stalled cycles (HAZARD_PERF_EN)
//   raw_stalls_o            cycles stalled by a RAW hazard (HAZARD_PERF_EN)
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 32,
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                id_valid_i,
  input  logic [6:0]          id_opcode_i,
  input  logic [4:0]          id_rs1_i,
  input  logic [4:0]          id_rs2_i,
  input  logic [4:0]          id_rd_i,
  input  logic                flush_i,
  input  logic                ll_wb_valid_i,
  input  logic [4:0]          ll_wb_rd_i,
  input  logic                drain_req_i,
  output logic                id_stall_o,
  output logic                drain_done_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic [OUT_W-1:0]    outstanding_o,
  output logic                ll_err_o,
  output logic [CNT_W-1:0]    stall_cycles_o,
  output logic [CNT_W-1:0]    raw_stalls_o
);

  localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0] pending_d, pending_q;
  logic [OUT_W-1:0]    outstanding_d, outstanding_q;
  logic                ll_err_d, ll_err_q;
  hz_state_e           state_d, state_q;

  logic [NUM_REGS-1:0] wb_mask, pend_eff;
  logic raw_hz, waw_hz, full_hz, drain_hz, id_is_ll, ll_fire;

  // A result sitting in WB this cycle is forwarded, so its register no
  // longer counts as pending for the instruction in ID.
  assign wb_mask  = ll_wb_valid_i ? (NUM_REGS'(1) << ll_wb_rd_i) : '0;
  assign pend_eff = pending_q & ~wb_mask;
  assign id_is_ll = is_ll(id_opcode_i);

  assign raw_hz   = (uses_rs1(id_opcode_i) && (id_rs1_i != REG_X0) && pend_eff[id_rs1_i]) ||
                    (uses_rs2(id_opcode_i) && (id_rs2_i != REG_X0) && pend_eff[id_rs2_i]);
  assign waw_hz   = writes_rd(id_opcode_i, id_rd_i) && pend_eff[id_rd_i];
  // A completion in the same cycle frees a slot for the new op.
  assign full_hz  = id_is_ll && (outstanding_q == MAX_CNT) && !ll_wb_valid_i;
  assign drain_hz = (state_q == DRAIN);

  assign id_stall_o = id_valid_i && !rst_i && (raw_hz || waw_hz || full_hz || drain_hz);
  assign ll_fire    = id_valid_i && !id_stall_o && !flush_i && id_is_ll;

  function automatic hz_state_e count_state(input logic [OUT_W-1:0] cnt);
    if (cnt == '0)      return IDLE;
    if (cnt == MAX_CNT) return FULL;
    return BUSY;
  endfunction

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    pending_d     = pending_q & ~wb_mask;
    outstanding_d = outstanding_q;
    ll_err_d      = ll_err_q;

    // Set after clear: an op issuing to the same rd that is retiring wins.
    if (ll_fire && (id_rd_i != REG_X0)) pending_d[id_rd_i] = 1'b1;
    pending_d[0] = 1'b0;

    if (ll_fire && !ll_wb_valid_i) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!ll_fire && ll_wb_valid_i && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end

    if (ll_wb_valid_i && (outstanding_q == '0)) ll_err_d = 1'b1;
  end

  // Transitions are taken on the next-state count; a drain request
  // overrides everything and DRAIN exits by count once it drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (outstanding_d != '0) state_d = count_state(outstanding_d);
      BUSY:    if ((outstanding_d == MAX_CNT) || (outstanding_d == '0))
                 state_d = count_state(outstanding_d);
      FULL:    if (outstanding_d != MAX_CNT) state_d = count_state(outstanding_d);
      DRAIN:   state_d = count_state(outstanding_d);
      default: state_d = IDLE;
    endcase
    if (drain_req_i) state_d = DRAIN;
  end

  // NOTE: state updates use non-blocking <= so every flop samples the
  // pre-edge values regardless of statement order.
  // NOTE: the pending bitmap is a flop vector, not a RAM, so it is reset
  // along with the rest of the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      ll_err_q      <= 1'b0;
      state_q       <= IDLE;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      ll_err_q      <= ll_err_d;
      state_q       <= state_d;
    end
  end

  assign pending_o     = pending_q;
  assign outstanding_o = outstanding_q;
  assign ll_err_o      = ll_err_q;
  assign drain_done_o  = (state_q == DRAIN) && (outstanding_q == '0);

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (id_stall_o),
    .cnt_o (stall_cycles_o)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_raw_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (id_stall_o && raw_hz),
    .cnt_o (raw_stalls_o)
  );
`else
  assign stall_cycles_o = '0;
  assign raw_stalls_o   = '0;
`endif

endmodule
